// File: rtl/writeback_arbiter.sv
// Register-bank write-port arbiter: ALU results win the port, load results
// bypass when possible or wait in an in-order FIFO that tracks pending writes.
module writeback_arbiter #(
  parameter int n     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [n-1:0]             alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [n-1:0]             mem_data,
  output logic                     regWrite,
  output logic [4:0]               write_register,
  output logic [n-1:0]             write_data,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]       rd_q   [DEPTH];
  logic [n-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             we_q, we_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [n-1:0]     wdata_q, wdata_d;

  logic alu_fire, accept, empty, pop, bypass, push, push_live;

  assign alu_fire  = alu_valid && (alu_rd != 5'd0);
  assign mem_ready = (cnt_q < CW'(DEPTH)) && !rst;
  assign accept    = mem_valid && mem_ready;
  assign empty     = (cnt_q == '0);
  assign pop       = !alu_fire && !empty;
  assign bypass    = !alu_fire && empty && accept && (mem_rd != 5'd0);
  assign push      = accept && (mem_rd != 5'd0) && !bypass;
  // A load arriving alongside an ALU write to the same register is already stale.
  assign push_live = !(alu_fire && (mem_rd == alu_rd));

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (alu_fire) begin
      we_d    = 1'b1;
      wreg_d  = alu_rd;
      wdata_d = alu_data;
    end else if (pop) begin
      if (live_q[rptr_q]) begin
        we_d    = 1'b1;
        wreg_d  = rd_q[rptr_q];
        wdata_d = data_q[rptr_q];
      end
    end else if (bypass) begin
      we_d    = 1'b1;
      wreg_d  = mem_rd;
      wdata_d = mem_data;
    end
  end

  always_comb begin
    live_d = live_q;
    if (alu_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rd_q[i] == alu_rd) live_d[i] = 1'b0;
      end
    end
    if (pop)  live_d[rptr_q] = 1'b0;
    if (push) live_d[wptr_q] = push_live;
  end

  always_comb begin
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_mask[rd_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      live_q  <= live_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  // Payload storage needs no reset: an entry is only observed while its live bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr_q]   <= mem_rd;
      data_q[wptr_q] <= mem_data;
    end
  end

  assign regWrite       = we_q;
  assign write_register = wreg_q;
  assign write_data     = wdata_q;
  assign fifo_count     = cnt_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid, mem_ready, regWrite;
  logic [4:0]    alu_rd, mem_rd, write_register;
  logic [N-1:0]  alu_data, mem_data, write_data;
  logic [31:0]   pending_mask;
  logic [2:0]    fifo_count;

  writeback_arbiter #(.n(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .regWrite(regWrite), .write_register(write_register), .write_data(write_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an ordered list of queued loads plus the write-port registers.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_reg;
  logic [63:0] m_data;

  function automatic logic [31:0] m_pend();
    logic [31:0] p = '0;
    foreach (q[i]) if (q[i].live) p[q[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_reg = '0; m_data = '0;
  endtask

  task automatic model_step(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                            input logic mv, input logic [4:0] mr, input logic [63:0] md);
    ent_t e;
    int   n0 = q.size();
    bit   acc = mv && (n0 < DEPTH);
    if (av && ar != 0) begin
      foreach (q[i]) if (q[i].rd == ar) begin e = q[i]; e.live = 0; q[i] = e; end
      m_we = 1; m_reg = ar; m_data = ad;
      if (acc && mr != 0) begin e.rd = mr; e.data = md; e.live = (mr != ar); q.push_back(e); end
    end else if (n0 > 0) begin
      e = q.pop_front();
      if (e.live) begin m_we = 1; m_reg = e.rd; m_data = e.data; end
      else m_we = 0;
      if (acc && mr != 0) begin e.rd = mr; e.data = md; e.live = 1; q.push_back(e); end
    end else if (acc && mr != 0) begin
      m_we = 1; m_reg = mr; m_data = md;
    end else begin
      m_we = 0;
    end
  endtask

  task automatic cycle(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [63:0] md,
                       output logic rdy);
    @(negedge clk);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
    #1;
    rdy = mem_ready;
    chk("mem_ready", 64'(mem_ready), 64'(q.size() < DEPTH));
    chk("pending_pre", 64'(pending_mask), 64'(m_pend()));
    chk("count_pre", 64'(fifo_count), 64'(q.size()));
    model_step(av, ar, ad, mv, mr, md);
    @(posedge clk);
    #1;
    chk("regWrite", 64'(regWrite), 64'(m_we));
    chk("write_register", 64'(write_register), 64'(m_reg));
    chk("write_data", write_data, m_data);
    chk("count_post", 64'(fifo_count), 64'(q.size()));
    chk("pending_post", 64'(pending_mask), 64'(m_pend()));
    if (regWrite) chk("x0_never_written", 64'(write_register != 0), 64'd1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        av; logic [4:0] ar; logic [63:0] ad;
    logic        mv; logic [4:0] mr; logic [63:0] md;
    logic        e_rdy; logic e_we; logic [4:0] e_reg; logic [63:0] e_data;
    logic [2:0]  e_cnt; logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic r;
    int   ld;
    logic mv;
    logic [4:0] wq[$];

    tbl[0]  = '{1, 5, 64'h1234, 0, 0, 64'h0,  1, 1, 5, 64'h1234, 0, 32'h0};
    tbl[1]  = '{0, 0, 64'h0,    0, 0, 64'h0,  1, 0, 5, 64'h1234, 0, 32'h0};
    tbl[2]  = '{1, 3, 64'hA,    1, 7, 64'hB,  1, 1, 3, 64'hA,    1, 32'h80};
    tbl[3]  = '{0, 0, 64'h0,    0, 0, 64'h0,  1, 1, 7, 64'hB,    0, 32'h0};
    tbl[4]  = '{1, 2, 64'h20,   1, 9, 64'h55, 1, 1, 2, 64'h20,   1, 32'h200};
    tbl[5]  = '{1, 9, 64'h66,   0, 0, 64'h0,  1, 1, 9, 64'h66,   1, 32'h0};
    tbl[6]  = '{0, 0, 64'h0,    0, 0, 64'h0,  1, 0, 9, 64'h66,   0, 32'h0};
    tbl[7]  = '{0, 0, 64'h0,    1, 0, 64'h88, 1, 0, 9, 64'h66,   0, 32'h0};
    tbl[8]  = '{1, 0, 64'h77,   0, 0, 64'h0,  1, 0, 9, 64'h66,   0, 32'h0};
    tbl[9]  = '{1, 0, 64'h11,   1, 4, 64'h44, 1, 1, 4, 64'h44,   0, 32'h0};
    tbl[10] = '{1, 6, 64'h60,   1, 6, 64'h61, 1, 1, 6, 64'h60,   1, 32'h0};
    tbl[11] = '{0, 0, 64'h0,    0, 0, 64'h0,  1, 0, 6, 64'h60,   0, 32'h0};
    tbl[12] = '{0, 0, 64'h0,    0, 0, 64'h0,  1, 0, 6, 64'h60,   0, 32'h0};

    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", 64'(regWrite), 64'd0);
    chk("rst_write_register", 64'(write_register), 64'd0);
    chk("rst_write_data", write_data, 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_pending", 64'(pending_mask), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md, r);
      chk($sformatf("vec%0d_ready", i), 64'(r), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_we", i), 64'(regWrite), 64'(tbl[i].e_we));
      chk($sformatf("vec%0d_reg", i), 64'(write_register), 64'(tbl[i].e_reg));
      chk($sformatf("vec%0d_data", i), write_data, tbl[i].e_data);
      chk($sformatf("vec%0d_cnt", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_pend", i), 64'(pending_mask), 64'(tbl[i].e_pend));
    end

    // FIFO full: ALU busy six cycles while five loads are offered back to back.
    reset_dut();
    ld = 0;
    for (int k = 0; k < 6; k++) begin
      mv = (ld < 5);
      cycle(1, 5'(k + 1), 64'(100 + k), mv, 5'(10 + ld), 64'(200 + ld), r);
      if (k == 4) chk("full_ready_c4", 64'(r), 64'd0);
      if (mv && r) ld++;
    end
    chk("full_accepted_4", 64'(ld), 64'd4);
    for (int k = 0; k < 8; k++) begin
      mv = (ld < 5);
      cycle(0, 0, 0, mv, 5'(10 + ld), 64'(200 + ld), r);
      if (mv && r) ld++;
      if (regWrite) wq.push_back(write_register);
    end
    chk("full_rd14_accepted", 64'(ld), 64'd5);
    chk("full_drain_len", 64'(wq.size()), 64'd5);
    for (int k = 0; k < 5 && k < wq.size(); k++)
      chk($sformatf("full_drain_order%0d", k), 64'(wq[k]), 64'(10 + k));

    // Asynchronous reset while three live loads are queued.
    reset_dut();
    for (int k = 0; k < 3; k++) cycle(1, 5'(k + 1), 64'(k), 1, 5'(20 + k), 64'(300 + k), r);
    chk("prerst_count", 64'(fifo_count), 64'd3);
    chk("prerst_pending", 64'(pending_mask), 64'h0070_0000);
    @(negedge clk);
    alu_valid = 0; mem_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_count", 64'(fifo_count), 64'd0);
    chk("midrst_pending", 64'(pending_mask), 64'd0);
    chk("midrst_regWrite", 64'(regWrite), 64'd0);
    chk("midrst_mem_ready", 64'(mem_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 0, 0, r);
      chk("postrst_ready", 64'(r), 64'd1);
      chk("postrst_no_write", 64'(regWrite), 64'd0);
    end

    // Randomized traffic with a narrow register range to provoke kills and stalls.
    reset_dut();
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), {$urandom, $urandom}, r);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
